// File: rtl/sram_mem_stage.sv
// Memory-stage SRAM access controller.
// Splits each 32-bit LDR/STR into two half-word phases on a 16-bit SRAM and
// freezes the pipeline until the access is complete.
module sram_mem_stage #(
    parameter int unsigned DATA_BASE     = 1024,
    parameter int unsigned ACCESS_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] address,
    input  logic [31:0] storeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic        freeze,
    output logic [17:0] sramAddr,
    output logic [15:0] sramDataOut,
    output logic        sramDataOe,
    output logic        sramWeN,
    input  logic [15:0] sramDataIn
);

    localparam int unsigned CntW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StHigh,
        StDone
    } state_e;

    state_e         state;
    logic [CntW-1:0] phase_cnt;
    logic [16:0]    index;
    logic           is_write;
    logic [31:0]    write_data;

    logic           request;
    logic           phase_last;
    logic [31:0]    word_offset;
    logic [16:0]    req_index;
    logic           unused_offset_bits;

    // Request decode and address-to-index mapping (wraps at 17 bits).
    always_comb begin
        request     = memRead | memWrite;
        phase_last  = (phase_cnt == CntLast);
        word_offset = (address - 32'(DATA_BASE)) >> 2;
        req_index   = word_offset[16:0];
    end

    assign unused_offset_bits = ^word_offset[31:17];

    // Access sequencer: latches the request, drives the SRAM bus per phase and
    // captures the two read halves on the last cycle of each phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            phase_cnt   <= '0;
            index       <= '0;
            is_write    <= 1'b0;
            write_data  <= '0;
            readData    <= '0;
            sramAddr    <= '0;
            sramDataOut <= '0;
            sramDataOe  <= 1'b0;
            sramWeN     <= 1'b1;
        end else begin
            unique case (state)
                StIdle: begin
                    if (request) begin
                        // A simultaneous read and write request is serviced as a write.
                        state      <= StLow;
                        phase_cnt  <= '0;
                        index      <= req_index;
                        is_write   <= memWrite;
                        write_data <= storeData;
                        sramAddr   <= {req_index, 1'b0};
                        sramDataOe <= memWrite;
                        sramWeN    <= ~memWrite;
                        if (memWrite) begin
                            sramDataOut <= storeData[15:0];
                        end
                    end
                end
                StLow: begin
                    if (phase_last) begin
                        state     <= StHigh;
                        phase_cnt <= '0;
                        sramAddr  <= {index, 1'b1};
                        if (is_write) begin
                            sramDataOut <= write_data[31:16];
                        end else begin
                            readData[15:0] <= sramDataIn;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                StHigh: begin
                    if (phase_last) begin
                        state      <= StDone;
                        phase_cnt  <= '0;
                        sramDataOe <= 1'b0;
                        sramWeN    <= 1'b1;
                        if (!is_write) begin
                            readData[31:16] <= sramDataIn;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                StDone: begin
                    // The request still on the inputs here is the one just served.
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // Handshake: idle passes through when nothing is asked for; done releases the stall.
    always_comb begin
        ready = 1'b0;
        unique case (state)
            StIdle:  ready = ~request;
            StLow:   ready = 1'b0;
            StHigh:  ready = 1'b0;
            StDone:  ready = 1'b1;
            default: ready = 1'b0;
        endcase
        freeze = ~ready;
    end

endmodule

// File: tb/tb_sram_mem_stage.sv
// Bench for sram_mem_stage: instance 0 uses one cycle per phase, instance 1 three.
// A transaction-level model predicts every output cycle by cycle; directed checks
// pin the hand-computed values.
module tb_sram_mem_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_read   [2];
    logic        mem_write  [2];
    logic [31:0] address    [2];
    logic [31:0] store_data [2];
    logic [31:0] read_data  [2];
    logic        ready      [2];
    logic        freeze     [2];
    logic [17:0] sram_addr  [2];
    logic [15:0] sram_dout  [2];
    logic        sram_oe    [2];
    logic        sram_wen   [2];
    logic [15:0] sram_din   [2];

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    logic [15:0] sram_mem  [int];
    logic [15:0] model_mem [int];

    sram_mem_stage #(.DATA_BASE(1024), .ACCESS_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .memRead(mem_read[0]), .memWrite(mem_write[0]),
        .address(address[0]), .storeData(store_data[0]), .readData(read_data[0]),
        .ready(ready[0]), .freeze(freeze[0]), .sramAddr(sram_addr[0]),
        .sramDataOut(sram_dout[0]), .sramDataOe(sram_oe[0]), .sramWeN(sram_wen[0]),
        .sramDataIn(sram_din[0])
    );

    sram_mem_stage #(.DATA_BASE(1024), .ACCESS_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst), .memRead(mem_read[1]), .memWrite(mem_write[1]),
        .address(address[1]), .storeData(store_data[1]), .readData(read_data[1]),
        .ready(ready[1]), .freeze(freeze[1]), .sramAddr(sram_addr[1]),
        .sramDataOut(sram_dout[1]), .sramDataOe(sram_oe[1]), .sramWeN(sram_wen[1]),
        .sramDataIn(sram_din[1])
    );

    function automatic int key(int i, int hw);
        return i * (1 << 18) + hw;
    endfunction

    function automatic logic [15:0] dflt(int k);
        return 16'(k) ^ 16'h5A5A;
    endfunction

    function automatic int acc(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [15:0] sram_rd(int k);
        return sram_mem.exists(k) ? sram_mem[k] : dflt(k);
    endfunction

    function automatic logic [15:0] model_rd(int k);
        return model_mem.exists(k) ? model_mem[k] : dflt(k);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // SRAM: writes while WE# is low, read data follows the address.
    initial begin
        sram_din[0] = '0;
        sram_din[1] = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (sram_wen[i] === 1'b0 && sram_oe[i] === 1'b1)
                    sram_mem[key(i, int'(sram_addr[i]))] = sram_dout[i];
                sram_din[i] = sram_rd(key(i, int'(sram_addr[i])));
            end
        end
    end

    // Model: an access seen in cycle 0 occupies positions 1..2*AC+1 (low, high, done).
    bit          m_busy [2];
    int          m_pos  [2];
    bit          m_wr   [2];
    int          m_idx  [2];
    logic [31:0] m_data [2];
    logic [31:0] m_rd   [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0;
            m_pos[i]  = 0;
            m_wr[i]   = 1'b0;
            m_idx[i]  = 0;
            m_data[i] = '0;
            m_rd[i]   = '0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    m_busy[i] = 1'b0;
                    m_rd[i]   = '0;
                end else if (m_busy[i]) begin
                    if (m_pos[i] == 2 * acc(i) + 1) begin
                        m_busy[i] = 1'b0;
                    end else begin
                        if (!m_wr[i] && m_pos[i] == acc(i))
                            m_rd[i][15:0] = model_rd(key(i, 2 * m_idx[i]));
                        if (!m_wr[i] && m_pos[i] == 2 * acc(i))
                            m_rd[i][31:16] = model_rd(key(i, 2 * m_idx[i] + 1));
                        m_pos[i]++;
                    end
                end else if (mem_read[i] || mem_write[i]) begin
                    m_busy[i] = 1'b1;
                    m_pos[i]  = 1;
                    m_wr[i]   = mem_write[i];
                    m_idx[i]  = int'(((address[i] - 32'd1024) >> 2) & 32'h1FFFF);
                    m_data[i] = store_data[i];
                    if (mem_write[i]) begin
                        model_mem[key(i, 2 * m_idx[i])]     = store_data[i][15:0];
                        model_mem[key(i, 2 * m_idx[i] + 1)] = store_data[i][31:16];
                    end
                end
            end
        end
    end

    // Compare every cycle, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                for (int i = 0; i < 2; i++) begin
                    logic exp_ready;
                    bit   in_phase;
                    bit   high;
                    in_phase  = m_busy[i] && m_pos[i] <= 2 * acc(i);
                    high      = m_pos[i] > acc(i);
                    exp_ready = m_busy[i] ? (m_pos[i] == 2 * acc(i) + 1)
                                          : !(mem_read[i] || mem_write[i]);
                    chk($sformatf("ready[%0d]", i), 32'(ready[i]), 32'(exp_ready));
                    chk($sformatf("freeze[%0d]", i), 32'(freeze[i]), 32'(!exp_ready));
                    chk($sformatf("readData[%0d]", i), read_data[i], m_rd[i]);
                    chk($sformatf("weN[%0d]", i), 32'(sram_wen[i]),
                        32'(!(in_phase && m_wr[i])));
                    chk($sformatf("oe[%0d]", i), 32'(sram_oe[i]), 32'(in_phase && m_wr[i]));
                    if (in_phase) begin
                        chk($sformatf("sramAddr[%0d]", i), 32'(sram_addr[i]),
                            32'(2 * m_idx[i] + (high ? 1 : 0)));
                        if (m_wr[i])
                            chk($sformatf("dataOut[%0d]", i), 32'(sram_dout[i]),
                                high ? 32'(m_data[i][31:16]) : 32'(m_data[i][15:0]));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] d);
        mem_read[i]   = r;
        mem_write[i]  = w;
        address[i]    = a;
        store_data[i] = d;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset ready", 32'(ready[i]), 1);
            chk("reset freeze", 32'(freeze[i]), 0);
            chk("reset weN", 32'(sram_wen[i]), 1);
            chk("reset oe", 32'(sram_oe[i]), 0);
            chk("reset readData", read_data[i], 0);
            chk("reset sramAddr", 32'(sram_addr[i]), 0);
            chk("reset dataOut", 32'(sram_dout[i]), 0);
        end
        checking = 1'b1;

        // No request: stays ready.
        for (int c = 0; c < 10; c++) begin
            step();
            #1;
            chk("idle ready", 32'(ready[0]), 1);
            chk("idle weN", 32'(sram_wen[0]), 1);
        end

        // Store 0xDEADBEEF at 1028; inputs scrambled mid-access.
        step(); drive(0, 0, 1, 1028, 32'hDEADBEEF); #1;
        chk("st c0 freeze", 32'(freeze[0]), 1);
        step(); #1;
        chk("st c1 addr", 32'(sram_addr[0]), 2);
        chk("st c1 dout", 32'(sram_dout[0]), 32'hBEEF);
        chk("st c1 weN", 32'(sram_wen[0]), 0);
        drive(0, 0, 1, 0, 0);
        step(); #1;
        chk("st c2 addr", 32'(sram_addr[0]), 3);
        chk("st c2 dout", 32'(sram_dout[0]), 32'hDEAD);
        step(); #1;
        chk("st c3 ready", 32'(ready[0]), 1);
        chk("st c3 weN", 32'(sram_wen[0]), 1);
        step(); drive(0, 0, 0, 0, 0);

        // Load it back.
        step(); drive(0, 1, 0, 1028, 0);
        step(); step(); step(); #1;
        chk("ld c3 readData", read_data[0], 32'hDEADBEEF);
        chk("ld c3 ready", 32'(ready[0]), 1);
        step(); drive(0, 0, 0, 0, 0);

        // Back-to-back STR then LDR at 1024.
        step(); drive(0, 0, 1, 1024, 32'h12345678);
        step(); step(); step(); #1;
        chk("b2b c3 ready", 32'(ready[0]), 1);
        step(); drive(0, 1, 0, 1024, 0); #1;
        chk("b2b c4 ready", 32'(ready[0]), 0);
        step(); #1;
        chk("b2b c5 addr", 32'(sram_addr[0]), 0);
        chk("b2b c5 weN", 32'(sram_wen[0]), 1);
        chk("b2b c5 ready", 32'(ready[0]), 0);
        step(); step(); #1;
        chk("b2b c7 readData", read_data[0], 32'h12345678);
        chk("b2b c7 ready", 32'(ready[0]), 1);
        step(); drive(0, 0, 0, 0, 0);

        // Read and write together: serviced as a write.
        step(); drive(0, 1, 1, 1032, 32'hCAFEF00D);
        step(); #1;
        chk("rw c1 weN", 32'(sram_wen[0]), 0);
        chk("rw c1 oe", 32'(sram_oe[0]), 1);
        step(); step(); #1;
        chk("rw c3 readData kept", read_data[0], 32'h12345678);
        step(); drive(0, 1, 0, 1032, 0);
        step(); step(); step(); #1;
        chk("rw readback", read_data[0], 32'hCAFEF00D);
        step(); drive(0, 0, 0, 0, 0);

        // Reset during the high phase of a write.
        step(); drive(0, 0, 1, 1040, 32'h55AA1234);
        step();
        step(); rst = 1'b1;
        step(); rst = 1'b0; drive(0, 0, 0, 0, 0); #1;
        chk("rst weN", 32'(sram_wen[0]), 1);
        chk("rst ready", 32'(ready[0]), 1);
        chk("rst readData", read_data[0], 0);
        chk("rst sramAddr", 32'(sram_addr[0]), 0);
        step(); drive(0, 1, 0, 1040, 0);
        step(); step(); step(); #1;
        chk("post-rst load", read_data[0], 32'h55AA1234);
        chk("post-rst ready", 32'(ready[0]), 1);
        step(); drive(0, 0, 0, 0, 0);

        // Three cycles per phase: LDR at 1024.
        sram_mem[key(1, 0)]  = 16'h7777;
        sram_mem[key(1, 1)]  = 16'h9999;
        model_mem[key(1, 0)] = 16'h7777;
        model_mem[key(1, 1)] = 16'h9999;
        step(); drive(1, 1, 0, 1024, 0); #1;
        chk("mc c0 freeze", 32'(freeze[1]), 1);
        for (int c = 1; c <= 7; c++) begin
            step(); #1;
            if (c <= 6) chk("mc addr", 32'(sram_addr[1]), (c <= 3) ? 0 : 1);
            chk("mc freeze", 32'(freeze[1]), (c < 7) ? 1 : 0);
        end
        chk("mc readData", read_data[1], 32'h99997777);
        step(); drive(1, 0, 0, 0, 0);

        // Three cycles per phase: write then read back at 1028.
        step(); drive(1, 0, 1, 1028, 32'h0BADF00D);
        for (int c = 1; c <= 7; c++) step();
        drive(1, 1, 0, 1028, 0);
        for (int c = 1; c <= 8; c++) step();
        #1;
        chk("mc readback", read_data[1], 32'h0BADF00D);
        drive(1, 0, 0, 0, 0);

        step(); step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
